// File: rtl/bcd_pkg.sv
// Shared widths and types for the 6-bit binary-to-BCD converter.
package bcd_pkg;
  localparam int BIN_W     = 6;
  localparam int DIGIT_W   = 4;
  localparam int DIGIT_MAX = 9;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;
  typedef logic [BIN_W-1:0]   bin6_t;
endpackage

// File: rtl/add3.sv
// Double-dabble correction cell: add 3 to a BCD nibble that is 5 or more.
module add3
  import bcd_pkg::*;
(
  input  bcd_digit_t in,
  output bcd_digit_t out
);
  // Inputs 10-15 never occur in the network, so their outputs are don't-care.
  assign out = (in >= bcd_digit_t'(5)) ? in + bcd_digit_t'(3) : in;
endmodule

// File: rtl/bcd_6b.sv
// Registered 6-bit binary-to-BCD converter: unrolled double-dabble network
// feeding a single output register with asynchronous active-low clear.
module bcd_6b
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  bin6_t      in,
  output bcd_digit_t ones,
  output bcd_digit_t tens
);
  bcd_digit_t w_c1, w_c2, w_c3;
  bcd_digit_t w_tens, w_ones;
  bcd_digit_t r_tens, r_ones;

  // The tens nibble never exceeds 3 before the final shift, so only the
  // ones nibble needs a correction cell in each of the three rows.
  add3 u_row1 (.in({1'b0, in[5:3]}),    .out(w_c1));
  add3 u_row2 (.in({w_c1[2:0], in[2]}), .out(w_c2));
  add3 u_row3 (.in({w_c2[2:0], in[1]}), .out(w_c3));

  assign w_tens = {1'b0, w_c1[3], w_c2[3], w_c3[3]};
  assign w_ones = {w_c3[2:0], in[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tens <= '0;
      r_ones <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      r_tens <= w_tens;
      r_ones <= w_ones;
    end
  end

  assign tens = r_tens;
  assign ones = r_ones;
endmodule

// File: tb/tb_bcd_6b.sv
// Self-checking bench for bcd_6b: directed scenarios plus random stimulus
// compared against an arithmetic divide/modulo reference.
module tb_bcd_6b;
  import bcd_pkg::*;

  logic       clk;
  logic       rst_n;
  bin6_t      in_v;
  bcd_digit_t ones, tens;
  bcd_digit_t a_in, a_out;

  int n_tests = 0;
  int n_fail  = 0;

  bcd_6b dut (.clk(clk), .rst_n(rst_n), .in(in_v), .ones(ones), .tens(tens));
  add3   u_add3 (.in(a_in), .out(a_out));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic int ref_tens(input int v);
    return v / 10;
  endfunction

  function automatic int ref_ones(input int v);
    return v % 10;
  endfunction

  // Apply a value at the falling edge, then advance to just after the next rising edge.
  task automatic drive(input int v);
    @(negedge clk);
    in_v = bin6_t'(v);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_v  = 6'd45;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (tens !== 4'd0 || ones !== 4'd0) begin
        n_fail++;
        $display("FAIL reset_hold: got %0d/%0d expected 0/0", tens, ones);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (tens !== 4'd4 || ones !== 4'd5) begin
      n_fail++;
      $display("FAIL reset_release: got %0d/%0d expected 4/5", tens, ones);
    end
  endtask

  task automatic test_boundaries();
    int vals [4] = '{0, 9, 10, 63};
    int exp_t [4] = '{0, 0, 1, 6};
    int exp_o [4] = '{0, 9, 0, 3};
    for (int i = 0; i < 4; i++) begin
      drive(vals[i]);
      n_tests++;
      if (tens !== bcd_digit_t'(exp_t[i]) || ones !== bcd_digit_t'(exp_o[i])) begin
        n_fail++;
        $display("FAIL boundary in=%0d: got %0d/%0d expected %0d/%0d",
                 vals[i], tens, ones, exp_t[i], exp_o[i]);
      end
    end
  endtask

  task automatic test_sweep();
    for (int v = 0; v < 64; v++) begin
      drive(v);
      n_tests++;
      if (tens !== bcd_digit_t'(ref_tens(v)) || ones !== bcd_digit_t'(ref_ones(v))) begin
        n_fail++;
        $display("FAIL sweep in=%0d: got %0d/%0d expected %0d/%0d",
                 v, tens, ones, ref_tens(v), ref_ones(v));
      end
      n_tests++;
      if (tens[3] !== 1'b0 || ones > bcd_digit_t'(DIGIT_MAX)) begin
        n_fail++;
        $display("FAIL sweep_range in=%0d: got %0d/%0d expected tens[3]=0 ones<=9",
                 v, tens, ones);
      end
    end
  endtask

  task automatic test_back_to_back();
    drive(19);
    n_tests++;
    if (tens !== 4'd1 || ones !== 4'd9) begin
      n_fail++;
      $display("FAIL b2b_19: got %0d/%0d expected 1/9", tens, ones);
    end
    @(negedge clk);
    in_v = 6'd20;
    #1;
    n_tests++;
    if (tens !== 4'd1 || ones !== 4'd9) begin
      n_fail++;
      $display("FAIL b2b_hold: got %0d/%0d expected 1/9", tens, ones);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (tens !== 4'd2 || ones !== 4'd0) begin
      n_fail++;
      $display("FAIL b2b_20: got %0d/%0d expected 2/0", tens, ones);
    end
  endtask

  task automatic test_async_reset();
    for (int v = 50; v < 54; v++) drive(v);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (tens !== 4'd0 || ones !== 4'd0) begin
      n_fail++;
      $display("FAIL async_clear: got %0d/%0d expected 0/0", tens, ones);
    end
    in_v = 6'd37;
    @(posedge clk);
    #1;
    n_tests++;
    if (tens !== 4'd0 || ones !== 4'd0) begin
      n_fail++;
      $display("FAIL async_hold: got %0d/%0d expected 0/0", tens, ones);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (tens !== 4'd3 || ones !== 4'd7) begin
      n_fail++;
      $display("FAIL async_release: got %0d/%0d expected 3/7", tens, ones);
    end
  endtask

  task automatic test_random();
    int v;
    for (int i = 0; i < 200; i++) begin
      v = int'($urandom_range(63, 0));
      drive(v);
      n_tests++;
      if (tens !== bcd_digit_t'(ref_tens(v)) || ones !== bcd_digit_t'(ref_ones(v))) begin
        n_fail++;
        $display("FAIL random in=%0d: got %0d/%0d expected %0d/%0d",
                 v, tens, ones, ref_tens(v), ref_ones(v));
      end
    end
  endtask

  task automatic test_add3();
    int exp_v;
    for (int v = 0; v < 10; v++) begin
      a_in = bcd_digit_t'(v);
      #1;
      exp_v = (v < 5) ? v : v + 3;
      n_tests++;
      if (a_out !== bcd_digit_t'(exp_v)) begin
        n_fail++;
        $display("FAIL add3 in=%0d: got %0d expected %0d", v, a_out, exp_v);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_v  = '0;
    a_in  = '0;
    test_reset();
    test_boundaries();
    test_sweep();
    test_back_to_back();
    test_async_reset();
    test_random();
    test_add3();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
